// File: rtl/or16way_arbiter.sv
// or16way_arbiter: round-robin sharing of one 16-way OR reducer among four requesters
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/req_data     : per-requester operand and valid
//   req_ready              : one-hot grant, only in IDLE
//   resp_valid/resp_ready  : response handshake
//   resp_out/resp_id       : OR result and the requester that produced it
module my_or16way (
    input  logic [15:0] i_a,
    output logic        o_y
);
    assign o_y = |i_a;
endmodule

module or16way_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0][15:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_out,
    output logic [1:0]            resp_id
);
    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_ptr, r_id, w_win;
    logic [15:0] r_opnd;
    logic        r_res, w_any, w_accept, w_or;

    my_or16way u_or (.i_a(r_opnd), .o_y(w_or));

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin
        w_win = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[r_ptr + 2'(k)]) w_win = r_ptr + 2'(k);
    end

    assign w_any      = |req_valid;
    assign w_accept   = (r_state == IDLE) && w_any;
    assign req_ready  = w_accept ? NREQ'(1) << w_win : '0;
    assign resp_valid = r_state == RESP;
    assign resp_out   = r_res;
    assign resp_id    = r_id;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? EVAL : IDLE;
            EVAL:    w_next = RESP;
            RESP:    w_next = resp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_opnd  <= '0;
            r_id    <= '0;
            r_res   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_opnd <= req_data[w_win];
                r_id   <= w_win;
                r_ptr  <= w_win + 2'd1;
            end
            if (r_state == EVAL) r_res <= w_or;
        end
    end
endmodule

// File: tb/tb_or16way_arbiter.sv
// tb_or16way_arbiter: directed self-checking bench for or16way_arbiter
module tb_or16way_arbiter;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req_valid = '0;
    logic [3:0][15:0] req_data = '0;
    logic [3:0]       req_ready;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic             resp_out;
    logic [1:0]       resp_id;
    int               n_cmp = 0;
    int               n_err = 0;

    or16way_arbiter #(.NREQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_out(resp_out), .resp_id(resp_id)
    );

    always #5 clk = ~clk;

    // One full transaction starting at a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic serve(input logic [3:0] v, output logic [3:0] gnt, output logic rv,
                         output logic ro, output logic [1:0] rid);
        req_valid = v;
        resp_ready = 1'b1;
        #1 gnt = req_ready;
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        @(posedge clk); @(negedge clk);
        rv = resp_valid; ro = resp_out; rid = resp_id;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
        n_cmp++; if (resp_out !== 1'b0) begin n_err++; $display("FAIL reset_out: got %b want 0", resp_out); end
        n_cmp++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", resp_id); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] g; logic rv, ro; logic [1:0] rid;
        req_data[0] = 16'h0000;
        serve(4'b0001, g, rv, ro, rid);
        n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", g); end
        n_cmp++; if (rv !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", rv); end
        n_cmp++; if (ro !== 1'b0) begin n_err++; $display("FAIL single_out: got %b want 0", ro); end
        n_cmp++; if (rid !== 2'd0) begin n_err++; $display("FAIL single_id: got %0d want 0", rid); end
        n_cmp++; if (dut.r_ptr !== 2'd1) begin n_err++; $display("FAIL single_ptr: got %0d want 1", dut.r_ptr); end
    endtask

    task automatic test_sweep();
        logic [3:0] g; logic rv, ro; logic [1:0] rid;
        logic [15:0] vec [4] = '{16'h0001, 16'h8000, 16'h0100, 16'hFFFF};
        for (int i = 0; i < 4; i++) begin
            req_data[2] = vec[i];
            serve(4'b0100, g, rv, ro, rid);
            n_cmp++; if (g !== 4'b0100) begin n_err++; $display("FAIL sweep_grant[%0d]: got %b want 0100", i, g); end
            n_cmp++; if ({rv, ro, rid} !== 4'b1110) begin n_err++; $display("FAIL sweep_resp[%0d]: got v%b o%b id%0d want v1 o1 id2", i, rv, ro, rid); end
            n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL sweep_idle[%0d]: got %b want 0", i, resp_valid); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g; logic rv, ro; logic [1:0] rid;
        pulse_reset();
        req_data = {16'h8000, 16'h0400, 16'h0000, 16'h0001};
        for (int n = 0; n < 8; n++) begin
            serve(4'b1111, g, rv, ro, rid);
            n_cmp++; if (g !== 4'(1 << (n % 4))) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", n, g, 4'(1 << (n % 4))); end
            n_cmp++; if (rid !== 2'(n % 4)) begin n_err++; $display("FAIL rr_id[%0d]: got %0d want %0d", n, rid, n % 4); end
            n_cmp++; if (ro !== ((n % 4) != 1)) begin n_err++; $display("FAIL rr_out[%0d]: got %b want %b", n, ro, (n % 4) != 1); end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] g; logic rv, ro; logic [1:0] rid;
        logic [3:0] vin [5] = '{4'b0010, 4'b0011, 4'b0011, 4'b0001, 4'b1001};
        logic [3:0] gex [5] = '{4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b1000};
        logic [1:0] iex [5] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd3};
        for (int i = 0; i < 5; i++) begin
            serve(vin[i], g, rv, ro, rid);
            n_cmp++; if (g !== gex[i]) begin n_err++; $display("FAIL rot_grant[%0d]: got %b want %b", i, g, gex[i]); end
            n_cmp++; if (rid !== iex[i]) begin n_err++; $display("FAIL rot_id[%0d]: got %0d want %0d", i, rid, iex[i]); end
        end
    endtask

    task automatic test_backpressure();
        req_data[0] = 16'h0010;
        req_valid = 4'b1111;
        resp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_grant: got %b want 0001", req_ready); end
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if ({resp_valid, resp_out, resp_id} !== 4'b1100) begin n_err++; $display("FAIL bp_hold[%0d]: got v%b o%b id%0d want v1 o1 id0", c, resp_valid, resp_out, resp_id); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready); end
            n_cmp++; if (dut.r_ptr !== 2'd1) begin n_err++; $display("FAIL bp_ptr[%0d]: got %0d want 1", c, dut.r_ptr); end
            @(posedge clk); @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", resp_valid); end
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_next_grant: got %b want 0010", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        req_data[3] = 16'h0200;
        req_valid = 4'b1000;
        resp_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({resp_valid, resp_out, resp_id} !== 4'b0000) begin n_err++; $display("FAIL arst_eval: got v%b o%b id%0d want all 0", resp_valid, resp_out, resp_id); end
        n_cmp++; if (dut.r_ptr !== 2'd0) begin n_err++; $display("FAIL arst_eval_ptr: got %0d want 0", dut.r_ptr); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL arst_eval_stale[%0d]: got %b want 0", c, resp_valid); end
        end
        req_data[2] = 16'hFFFF;
        req_valid = 4'b0100;
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if ({resp_valid, resp_out, resp_id} !== 4'b1110) begin n_err++; $display("FAIL arst_pre_resp: got v%b o%b id%0d want v1 o1 id2", resp_valid, resp_out, resp_id); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({resp_valid, resp_out, resp_id} !== 4'b0000) begin n_err++; $display("FAIL arst_resp: got v%b o%b id%0d want all 0", resp_valid, resp_out, resp_id); end
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL arst_resp_stale[%0d]: got %b want 0", c, resp_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_round_robin();
        test_rotation();
        test_backpressure();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
